muldiv_arb: RTL and testbench

MULDIV_ARB -- requirements
Module: muldiv_arb

---
 rtl/muldiv_arb.sv | 116 +++++++++++
 tb/tb_muldiv_arb.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_arb.sv
// Two-requester front end for a shared multiply/divide unit: grants one request
// at a time, holds the operation stable on the unit, and returns the result to its owner.
module muldiv_arb #(
  parameter int XLEN = 64,
  parameter int NREQ = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_is_div,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [NREQ-1:0]      req_word,
  input  logic [NREQ*XLEN-1:0] req_in1,
  input  logic [NREQ*XLEN-1:0] req_in2,
  output logic                 fu_mul_en,
  output logic                 fu_div_en,
  output logic [1:0]           fu_op,
  output logic                 fu_word,
  output logic [XLEN-1:0]      fu_in1,
  output logic [XLEN-1:0]      fu_in2,
  output logic                 fu_kill,
  input  logic [XLEN-1:0]      fu_out,
  input  logic                 fu_out_valid,
  output logic                 fu_out_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [XLEN-1:0]      rsp_data,
  input  logic [NREQ-1:0]      rsp_ready
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            state;
  logic              rr_ptr;
  logic              owner;
  logic              is_div;
  logic [1:0]        op;
  logic              word;
  logic [XLEN-1:0]   in1;
  logic [XLEN-1:0]   in2;
  logic [XLEN-1:0]   result;
  logic              gnt_idx;
  logic              accept;

  // Sole valid requester wins; the round-robin pointer only breaks ties.
  always_comb begin
    gnt_idx   = (&req_valid) ? rr_ptr : req_valid[1];
    req_ready = '0;
    if (state == S_IDLE && !flush && (|req_valid))
      req_ready[gnt_idx] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  assign fu_mul_en    = (state == S_BUSY) && !is_div && !reset;
  assign fu_div_en    = (state == S_BUSY) && is_div && !reset;
  assign fu_op        = op;
  assign fu_word      = word;
  assign fu_in1       = in1;
  assign fu_in2       = in2;
  assign fu_kill      = flush && (state == S_BUSY) && !reset;
  assign fu_out_ready = (state == S_BUSY) && !reset;
  assign rsp_data     = reset ? '0 : result;

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP && !flush && !reset)
      rsp_valid[owner] = 1'b1;
  end

  // Flush wins over every handshake in the same cycle and leaves the pointer alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      rr_ptr <= 1'b0;
      owner  <= 1'b0;
      is_div <= 1'b0;
      op     <= '0;
      word   <= 1'b0;
      in1    <= '0;
      in2    <= '0;
      result <= '0;
    end else if (flush) begin
      state  <= S_IDLE;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner  <= gnt_idx;
            rr_ptr <= ~gnt_idx;
            is_div <= gnt_idx ? req_is_div[1] : req_is_div[0];
            op     <= gnt_idx ? req_op[3:2] : req_op[1:0];
            word   <= gnt_idx ? req_word[1] : req_word[0];
            in1    <= gnt_idx ? req_in1[2*XLEN-1:XLEN] : req_in1[XLEN-1:0];
            in2    <= gnt_idx ? req_in2[2*XLEN-1:XLEN] : req_in2[XLEN-1:0];
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (fu_out_valid) begin
            result <= fu_out;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[owner])
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_arb.sv
// Bench for muldiv_arb: directed handshake/flush/reset cases, then randomized
// traffic against a reference unit model with a per-requester response scoreboard.
module tb_muldiv_arb;

  localparam int XLEN = 64;
  localparam int NOPS = 60;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [1:0]        req_is_div = '0;
  logic [3:0]        req_op = '0;
  logic [1:0]        req_word = '0;
  logic [2*XLEN-1:0] req_in1 = '0;
  logic [2*XLEN-1:0] req_in2 = '0;
  logic              fu_mul_en, fu_div_en, fu_word, fu_kill, fu_out_ready;
  logic [1:0]        fu_op;
  logic [XLEN-1:0]   fu_in1, fu_in2;
  logic [XLEN-1:0]   fu_out;
  logic              fu_out_valid;
  logic [1:0]        rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic [1:0]        rsp_ready = '0;

  // Unit response comes from the automatic model or from directed stimulus.
  logic              auto_unit = 1'b0;
  logic              u_fov = 1'b0, m_fov = 1'b0;
  logic [XLEN-1:0]   u_fo = '0, m_fo = '0;
  assign fu_out_valid = auto_unit ? u_fov : m_fov;
  assign fu_out       = auto_unit ? u_fo : m_fo;

  int total = 0;
  int bad = 0;
  int npush = 0;
  int ncomp = 0;
  logic [XLEN-1:0] exp_q0[$];
  logic [XLEN-1:0] exp_q1[$];

  logic            r_div[2];
  logic [1:0]      r_op[2];
  logic            r_word[2];
  logic [XLEN-1:0] r_a[2];
  logic [XLEN-1:0] r_b[2];

  muldiv_arb #(.XLEN(XLEN), .NREQ(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_div(req_is_div),
    .req_op(req_op), .req_word(req_word), .req_in1(req_in1), .req_in2(req_in2),
    .fu_mul_en(fu_mul_en), .fu_div_en(fu_div_en), .fu_op(fu_op), .fu_word(fu_word),
    .fu_in1(fu_in1), .fu_in2(fu_in2), .fu_kill(fu_kill), .fu_out(fu_out),
    .fu_out_valid(fu_out_valid), .fu_out_ready(fu_out_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 clock = ~clock;

  // What a shared mul/div unit would compute for one operation.
  function automatic logic [XLEN-1:0] ref_unit(input logic d, input logic [1:0] o,
                                               input logic w, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    if (!d) r = a * b;
    else    r = (b == '0) ? '1 : a / b;
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r ^ {{(XLEN-2){1'b0}}, o};
  endfunction

  task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_fields();
    req_is_div = {r_div[1], r_div[0]};
    req_op     = {r_op[1], r_op[0]};
    req_word   = {r_word[1], r_word[0]};
    req_in1    = {r_a[1], r_a[0]};
    req_in2    = {r_b[1], r_b[0]};
  endtask

  task automatic set_req(input int r, input logic d, input logic [1:0] o, input logic w,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    r_div[r] = d; r_op[r] = o; r_word[r] = w; r_a[r] = a; r_b[r] = b;
    drive_fields();
  endtask

  task automatic push_exp(input int r, input logic [XLEN-1:0] v);
    npush++;
    if (r == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b10;
    cyc();
    cyc();
    #1;
    check("rst_req_ready", req_ready, 2'b10);
    check("rst_fu_en", {fu_mul_en, fu_div_en}, 2'b00);
    check("rst_fu_out_ready", fu_out_ready, 1'b0);
    check("rst_fu_kill", fu_kill, 1'b0);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, '0);
    req_valid = 2'b00;
    cyc();
    reset = 1'b0;
  endtask

  // One operation driven by hand from the IDLE cycle in which it is accepted.
  task automatic man_op(input logic [1:0] rdy, input logic dv, input logic [XLEN-1:0] res,
                        input int lat, input int wt, input logic drop);
    int o;
    o = rdy[1] ? 1 : 0;
    #1;
    check("grant", req_ready, rdy);
    push_exp(o, res);
    for (int i = 1; i <= lat; i++) begin
      cyc();
      if (drop) req_valid = 2'b00;
      m_fov = (i == lat);
      m_fo  = res;
      #1;
      check("busy_req_ready", req_ready, 2'b00);
      check("busy_en", {fu_mul_en, fu_div_en}, {~dv, dv});
      check("busy_fu_in1", fu_in1, r_a[o]);
      check("busy_fu_in2", fu_in2, r_b[o]);
      check("busy_fu_op", {fu_word, fu_op}, {r_word[o], r_op[o]});
    end
    cyc();
    for (int i = 0; i < wt; i++) begin
      rsp_ready = ~rdy;
      m_fov = 1'b1;
      m_fo  = ~res;
      #1;
      check("hold_rsp_valid", rsp_valid, rdy);
      check("hold_rsp_data", rsp_data, res);
      check("hold_req_ready", req_ready, 2'b00);
      cyc();
    end
    m_fov = 1'b0;
    rsp_ready = rdy;
    #1;
    check("resp_valid", rsp_valid, rdy);
    check("resp_en_off", {fu_mul_en, fu_div_en}, 2'b00);
    cyc();
    rsp_ready = 2'b00;
  endtask

  // Scoreboard monitor: every owner handshake pops that requester's expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && !flush) begin
        if (rsp_valid == 2'b11) begin
          total++; bad++;
          $display("FAIL rsp_onehot actual=%b required=at most one bit", rsp_valid);
        end
        if (rsp_valid[0] && rsp_ready[0]) begin
          ncomp++;
          if (exp_q0.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp0_unexpected actual=%h required=no response", rsp_data);
          end else check("rsp0_data", rsp_data, exp_q0.pop_front());
        end
        if (rsp_valid[1] && rsp_ready[1]) begin
          ncomp++;
          if (exp_q1.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp1_unexpected actual=%h required=no response", rsp_data);
          end else check("rsp1_data", rsp_data, exp_q1.pop_front());
        end
      end
      if (req_ready == 2'b11) begin
        total++; bad++;
        $display("FAIL req_ready_onehot actual=%b required=at most one bit", req_ready);
      end
    end
  end

  // Automatic unit: random latency, checks operands stay put while enabled.
  initial begin
    logic ubusy, kill, done;
    int cnt;
    logic [XLEN-1:0] ures, sin1, sin2;
    ubusy = 1'b0;
    cnt = 0;
    ures = '0; sin1 = '0; sin2 = '0;
    forever begin
      @(negedge clock);
      kill = reset || fu_kill;
      done = u_fov && fu_out_ready;
      if (auto_unit) begin
        if (!ubusy && !u_fov && (fu_mul_en || fu_div_en) && !kill) begin
          ubusy = 1'b1;
          cnt = $urandom_range(1, 4);
          ures = ref_unit(fu_div_en, fu_op, fu_word, fu_in1, fu_in2);
          sin1 = fu_in1;
          sin2 = fu_in2;
        end else if (ubusy && (fu_mul_en || fu_div_en)) begin
          check("fu_stable", {fu_in1, fu_in2}, {sin1, sin2});
        end
      end
      @(posedge clock);
      #1;
      if (kill || done || !auto_unit) begin
        ubusy = 1'b0;
        u_fov = 1'b0;
      end else if (ubusy && !u_fov) begin
        cnt--;
        if (cnt == 0) begin
          u_fov = 1'b1;
          u_fo  = ures;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pend[2];
    logic [1:0] acc;
    int g, last, issued, r;
    for (int i = 0; i < 2; i++) begin
      r_div[i] = 0; r_op[i] = '0; r_word[i] = 0; r_a[i] = '0; r_b[i] = '0;
    end
    drive_fields();
    do_reset();

    // 6*7 multiply with a three-cycle unit
    set_req(0, 1'b0, 2'b00, 1'b0, 64'd6, 64'd7);
    req_valid = 2'b01;
    man_op(2'b01, 1'b0, 64'd42, 3, 0, 1'b1);

    // Both requesters held valid: round robin from requester 0
    do_reset();
    set_req(0, 1'b0, 2'b01, 1'b0, 64'd11, 64'd13);
    set_req(1, 1'b0, 2'b10, 1'b1, 64'hFFFF_0000_8000_0001, 64'd3);
    req_valid = 2'b11;
    man_op(2'b01, 1'b0, ref_unit(1'b0, 2'b01, 1'b0, 64'd11, 64'd13), 2, 0, 1'b0);
    man_op(2'b10, 1'b0, ref_unit(1'b0, 2'b10, 1'b1, 64'hFFFF_0000_8000_0001, 64'd3), 1, 0, 1'b0);
    req_valid = 2'b00;

    // Divide whose response is back-pressured for five cycles
    set_req(1, 1'b1, 2'b10, 1'b0, 64'd100, 64'd7);
    req_valid = 2'b10;
    man_op(2'b10, 1'b1, ref_unit(1'b1, 2'b10, 1'b0, 64'd100, 64'd7), 2, 5, 1'b1);

    // Flush in the second busy cycle of a divide
    set_req(0, 1'b1, 2'b00, 1'b0, 64'd50, 64'd5);
    req_valid = 2'b01;
    #1;
    check("fl_grant", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    #1;
    check("fl_busy1_div_en", fu_div_en, 1'b1);
    check("fl_busy1_kill", fu_kill, 1'b0);
    cyc();
    flush = 1'b1;
    #1;
    check("fl_kill", fu_kill, 1'b1);
    check("fl_rsp_valid", rsp_valid, 2'b00);
    cyc();
    flush = 1'b0;
    #1;
    check("fl_after_div_en", fu_div_en, 1'b0);
    check("fl_after_kill", fu_kill, 1'b0);
    set_req(1, 1'b0, 2'b11, 1'b0, 64'd9, 64'd9);
    req_valid = 2'b10;
    man_op(2'b10, 1'b0, ref_unit(1'b0, 2'b11, 1'b0, 64'd9, 64'd9), 1, 0, 1'b1);

    // Flush coinciding with the owner's response handshake
    set_req(0, 1'b0, 2'b00, 1'b0, 64'd2, 64'd2);
    req_valid = 2'b11;
    #1;
    check("fr_grant", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    m_fov = 1'b1;
    m_fo  = 64'h1234;
    cyc();
    m_fov = 1'b0;
    #1;
    check("fr_rsp_valid", rsp_valid, 2'b01);
    flush = 1'b1;
    rsp_ready = 2'b01;
    #1;
    check("fr_flush_rsp_valid", rsp_valid, 2'b00);
    check("fr_flush_fu_kill", fu_kill, 1'b0);
    cyc();
    flush = 1'b0;
    #1;
    check("fr_after_rsp_valid", rsp_valid, 2'b00);
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    flush = 1'b1;
    #1;
    check("fr_idle_flush_ready", req_ready, 2'b00);
    cyc();
    flush = 1'b0;
    man_op(2'b10, 1'b0, ref_unit(1'b0, 2'b11, 1'b0, 64'd9, 64'd9), 1, 0, 1'b1);

    // Reset while a 0xDEAD response is waiting
    set_req(0, 1'b1, 2'b01, 1'b0, 64'd77, 64'd1);
    req_valid = 2'b01;
    #1;
    check("rr_grant", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    m_fov = 1'b1;
    m_fo  = 64'hDEAD;
    cyc();
    m_fov = 1'b0;
    #1;
    check("rr_rsp_data", rsp_data, 64'hDEAD);
    check("rr_rsp_valid", rsp_valid, 2'b01);
    reset = 1'b1;
    #1;
    check("rr_during_rsp_valid", rsp_valid, 2'b00);
    check("rr_during_kill", fu_kill, 1'b0);
    cyc();
    reset = 1'b0;
    req_valid = 2'b11;
    #1;
    check("rr_after_rsp_valid", rsp_valid, 2'b00);
    check("rr_after_rsp_data", rsp_data, '0);
    check("rr_after_grant", req_ready, 2'b01);
    req_valid = 2'b00;

    // Randomized traffic
    auto_unit = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last = 1;
    issued = 0;
    for (int c = 0; c < 4000; c++) begin
      if (issued >= NOPS && !pend[0] && !pend[1]) break;
      @(negedge clock);
      acc = req_valid & req_ready;
      if (acc != 2'b00) begin
        g = (req_valid == 2'b11) ? 1 - last : (req_valid[1] ? 1 : 0);
        check("rand_grant", acc, (g == 1) ? 2'b10 : 2'b01);
        last = g;
        r = acc[1] ? 1 : 0;
        push_exp(r, ref_unit(r_div[r], r_op[r], r_word[r], r_a[r], r_b[r]));
        pend[r] = 1'b0;
      end
      @(posedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && issued < NOPS && $urandom_range(0, 2) == 0) begin
          r_div[k]  = $urandom_range(0, 1);
          r_op[k]   = 2'($urandom_range(0, 3));
          r_word[k] = $urandom_range(0, 1);
          r_a[k]    = {$urandom, $urandom};
          r_b[k]    = ($urandom_range(0, 7) == 0) ? '0 : {32'd0, $urandom};
          pend[k]   = 1'b1;
          issued++;
        end
      end
      drive_fields();
      req_valid = {pend[1], pend[0]};
      rsp_ready = 2'($urandom_range(0, 3));
    end
    check("rand_all_accepted", {pend[1], pend[0]}, 2'b00);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int i = 0; i < 200; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      cyc();
    end
    cyc();
    check("drain_left", exp_q0.size() + exp_q1.size(), 0);
    check("completed", ncomp, npush);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
